// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - shared state encoding and default widths for the paint controller
package paint_pkg;

    localparam int COORD_W_DEF = 6;
    localparam int COLOR_W_DEF = 8;
    localparam int BRUSH_W_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SAMPLE      = 3'd1,
        ST_DECODE      = 3'd2,
        ST_CURSOR      = 3'd3,
        ST_PALETTE     = 3'd4,
        ST_PAL_CONFIRM = 3'd5,
        ST_SET_COLOR   = 3'd6,
        ST_STAMP       = 3'd7
    } state_t;

endpackage

// File: rtl/paint_ctrl_brush_if.sv
// rtl/paint_ctrl_brush_if.sv - key/overlay/framebuffer signal bundle around the paint controller
interface paint_ctrl_brush_if #(
    parameter int COORD_W = paint_pkg::COORD_W_DEF,
    parameter int COLOR_W = paint_pkg::COLOR_W_DEF,
    parameter int BRUSH_W = paint_pkg::BRUSH_W_DEF
);
    logic               init;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               key_pal;
    logic               key_enter;
    logic               key_enter_pal;
    logic               erase;
    logic [BRUSH_W-1:0] brush_size;
    logic               cursor_done;
    logic [COLOR_W-1:0] cursor_px;
    logic               pal_done;
    logic [COLOR_W-1:0] pal_px;
    logic               wr_ready;
    logic               cursor_start;
    logic               pal_start;
    logic               wr_en;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [COLOR_W-1:0] px_data;
    logic [COLOR_W-1:0] color;
    logic               busy;

    // slave = the controller, master = its surroundings
    modport slave (
        input  init, cur_x, cur_y, key_pal, key_enter, key_enter_pal, erase,
               brush_size, cursor_done, cursor_px, pal_done, pal_px, wr_ready,
        output cursor_start, pal_start, wr_en, wr_x, wr_y, px_data, color, busy
    );

    modport master (
        output init, cur_x, cur_y, key_pal, key_enter, key_enter_pal, erase,
               brush_size, cursor_done, cursor_px, pal_done, pal_px, wr_ready,
        input  cursor_start, pal_start, wr_en, wr_x, wr_y, px_data, color, busy
    );
endinterface

// File: rtl/paint_ctrl_brush_stamper.sv
// rtl/paint_ctrl_brush_stamper.sv - walks an NxN brush square, clipping off-panel pixels
module brush_stamper #(
    parameter int COORD_W  = paint_pkg::COORD_W_DEF,
    parameter int COLOR_W  = paint_pkg::COLOR_W_DEF,
    parameter int BRUSH_W  = paint_pkg::BRUSH_W_DEF,
    parameter int MATRIX_W = 64,
    parameter int MATRIX_H = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_anchor_x,
    input  logic [COORD_W-1:0] i_anchor_y,
    input  logic [BRUSH_W-1:0] i_size,
    input  logic [COLOR_W-1:0] i_data,
    input  logic               i_wr_ready,
    output logic               o_wr_en,
    output logic [COORD_W-1:0] o_wr_x,
    output logic [COORD_W-1:0] o_wr_y,
    output logic [COLOR_W-1:0] o_wr_data,
    output logic               o_done
);
    localparam logic [COORD_W:0] LP_MAX_X = (COORD_W+1)'(MATRIX_W);
    localparam logic [COORD_W:0] LP_MAX_Y = (COORD_W+1)'(MATRIX_H);

    logic [BRUSH_W-1:0] r_dx;
    logic [BRUSH_W-1:0] r_dy;
    logic [COORD_W:0]   w_tx;
    logic [COORD_W:0]   w_ty;
    logic               w_in_panel;
    logic               w_adv;
    logic               w_last;

    // one extra bit so anchor+offset past the panel edge is clipped, not wrapped
    assign w_tx       = {1'b0, i_anchor_x} + (COORD_W+1)'(r_dx);
    assign w_ty       = {1'b0, i_anchor_y} + (COORD_W+1)'(r_dy);
    assign w_in_panel = (w_tx < LP_MAX_X) && (w_ty < LP_MAX_Y);
    assign w_adv      = i_start && (!w_in_panel || i_wr_ready);
    assign w_last     = (r_dx == i_size) && (r_dy == i_size);

    assign o_wr_en   = i_start && w_in_panel;
    assign o_wr_x    = w_tx[COORD_W-1:0];
    assign o_wr_y    = w_ty[COORD_W-1:0];
    assign o_wr_data = i_data;
    assign o_done    = w_adv && w_last;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (!i_start || o_done) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (w_adv) begin
            if (r_dx == i_size) begin
                r_dx <= '0;
                r_dy <= r_dy + 1'b1;
            end else begin
                r_dx <= r_dx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paint_ctrl_brush.sv
// rtl/paint_ctrl_brush.sv - paint control FSM: cursor/palette overlays, colour register, brush stamping
module paint_ctrl_brush
    import paint_pkg::*;
#(
    parameter int                 COORD_W       = COORD_W_DEF,
    parameter int                 COLOR_W       = COLOR_W_DEF,
    parameter int                 BRUSH_W       = BRUSH_W_DEF,
    parameter int                 MATRIX_W      = 64,
    parameter int                 MATRIX_H      = 64,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR      = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    paint_ctrl_brush_if.slave bus
);
    state_t             r_state;
    state_t             w_next;
    logic [COORD_W-1:0] r_ax;
    logic [COORD_W-1:0] r_ay;
    logic [BRUSH_W-1:0] r_size;
    logic               r_erase;
    logic               r_kpal;
    logic               r_kent;
    logic [COLOR_W-1:0] r_color;
    logic [COLOR_W-1:0] w_wr_data;
    logic               w_stamp;
    logic               w_done;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ax    <= '0;
            r_ay    <= '0;
            r_size  <= '0;
            r_erase <= 1'b0;
            r_kpal  <= 1'b0;
            r_kent  <= 1'b0;
            r_color <= DEFAULT_COLOR;
        end else begin
            r_state <= w_next;
            if (r_state == ST_SAMPLE) begin
                r_ax    <= bus.cur_x;
                r_ay    <= bus.cur_y;
                r_size  <= bus.brush_size;
                r_erase <= bus.erase;
                r_kpal  <= bus.key_pal;
                r_kent  <= bus.key_enter;
            end
            // colour is taken from the live cursor, not the sampled anchor
            if (r_state == ST_SET_COLOR) begin
                r_color <= {bus.cur_x[COLOR_W/2-1:0], bus.cur_y[COLOR_W/2-1:0]};
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:        if (bus.init) w_next = ST_SAMPLE;
            ST_SAMPLE:      w_next = bus.init ? ST_DECODE : ST_IDLE;
            ST_DECODE: begin
                if (r_kpal)      w_next = ST_PALETTE;
                else if (r_kent) w_next = ST_STAMP;
                else             w_next = ST_CURSOR;
            end
            ST_CURSOR:      if (bus.cursor_done) w_next = ST_SAMPLE;
            ST_PALETTE:     if (bus.pal_done) w_next = ST_PAL_CONFIRM;
            ST_PAL_CONFIRM: w_next = bus.key_enter_pal ? ST_SET_COLOR : ST_PALETTE;
            ST_SET_COLOR:   w_next = ST_SAMPLE;
            ST_STAMP:       if (w_done) w_next = ST_SAMPLE;
            default:        w_next = ST_IDLE;
        endcase
    end

    assign w_stamp   = (r_state == ST_STAMP);
    assign w_wr_data = r_erase ? BG_COLOR : r_color;

    brush_stamper #(
        .COORD_W  (COORD_W),
        .COLOR_W  (COLOR_W),
        .BRUSH_W  (BRUSH_W),
        .MATRIX_W (MATRIX_W),
        .MATRIX_H (MATRIX_H)
    ) u_stamper (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_stamp),
        .i_anchor_x (r_ax),
        .i_anchor_y (r_ay),
        .i_size     (r_size),
        .i_data     (w_wr_data),
        .i_wr_ready (bus.wr_ready),
        .o_wr_en    (bus.wr_en),
        .o_wr_x     (bus.wr_x),
        .o_wr_y     (bus.wr_y),
        .o_wr_data  (),
        .o_done     (w_done)
    );

    always_comb begin
        bus.px_data = '0;
        case (r_state)
            ST_CURSOR:  bus.px_data = bus.cursor_px;
            ST_PALETTE: bus.px_data = bus.pal_px;
            ST_STAMP:   bus.px_data = w_wr_data;
            default:    bus.px_data = '0;
        endcase
    end

    assign bus.cursor_start = (r_state == ST_CURSOR);
    assign bus.pal_start    = (r_state == ST_PALETTE);
    assign bus.color        = r_color;
    assign bus.busy         = (r_state != ST_IDLE) && (r_state != ST_SAMPLE);

endmodule

// File: tb/tb_paint_ctrl_brush.sv
// tb/tb_paint_ctrl_brush.sv - directed self-checking bench for paint_ctrl_brush
module tb_paint_ctrl_brush;
    import paint_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   wcount = 0;
    int   viol;

    paint_ctrl_brush_if bus ();

    paint_ctrl_brush dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // registers move on the falling edge; count accepted writes there
    always @(negedge clk) begin
        if (bus.wr_en && bus.wr_ready) wcount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.init = 0; bus.cur_x = 0; bus.cur_y = 0; bus.key_pal = 0; bus.key_enter = 0;
        bus.key_enter_pal = 0; bus.erase = 0; bus.brush_size = 0; bus.cursor_done = 0;
        bus.cursor_px = 0; bus.pal_done = 0; bus.pal_px = 0; bus.wr_ready = 1;

        #1 rst = 1;
        #1;
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_cursor_start", 32'(bus.cursor_start), 0);
        chk("rst_px_data", 32'(bus.px_data), 0);
        chk("rst_color", 32'(bus.color), 32'hFF);
        tick(); tick();
        rst = 0;
        bus.init = 1;

        // no keys -> cursor overlay
        tick(); tick(); tick();
        bus.cursor_px = 8'h3C;
        #1;
        chk("cursor_start", 32'(bus.cursor_start), 1);
        chk("cursor_busy", 32'(bus.busy), 1);
        chk("cursor_px_data", 32'(bus.px_data), 32'h3C);
        bus.cursor_done = 1;
        tick();
        bus.cursor_done = 0;
        chk("cursor_back_sample", 32'(dut.r_state), 32'(ST_SAMPLE));
        chk("cursor_color", 32'(bus.color), 32'hFF);

        // 2x2 stamp at (10,20)
        bus.cur_x = 10; bus.cur_y = 20; bus.brush_size = 1; bus.key_enter = 1;
        tick();
        bus.key_enter = 0;
        tick();
        chk("s1_p0", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd10, 8'd20, 8'hFF});
        tick();
        chk("s1_p1", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd11, 8'd20, 8'hFF});
        tick();
        chk("s1_p2", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd10, 8'd21, 8'hFF});
        tick();
        chk("s1_p3", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd11, 8'd21, 8'hFF});
        tick();
        chk("s1_end_wr_en", 32'(bus.wr_en), 0);
        chk("s1_end_state", 32'(dut.r_state), 32'(ST_SAMPLE));
        chk("s1_writes", 32'(wcount), 4);

        // 4x4 stamp in the corner: only (63,63) lands on the panel
        bus.cur_x = 63; bus.cur_y = 63; bus.brush_size = 3; bus.key_enter = 1;
        tick();
        bus.key_enter = 0;
        tick();
        chk("s2_p0", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, 8'd0}, {1'b1, 7'd0, 8'd63, 8'd63, 8'd0});
        viol = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.wr_en !== 1'b0 || dut.r_state !== ST_STAMP) viol++;
        end
        chk("s2_clipped_cycles", 32'(viol), 0);
        tick();
        chk("s2_end_state", 32'(dut.r_state), 32'(ST_SAMPLE));
        chk("s2_writes", 32'(wcount), 5);

        // palette: decline once, then confirm with cursor (5,10)
        bus.key_pal = 1;
        tick();
        bus.key_pal = 0;
        tick();
        bus.pal_px = 8'h77;
        #1;
        chk("pal_start", 32'(bus.pal_start), 1);
        chk("pal_excl", {29'd0, bus.cursor_start, bus.wr_en, bus.busy}, 32'b001);
        chk("pal_px_data", 32'(bus.px_data), 32'h77);
        bus.pal_done = 1;
        tick();
        bus.pal_done = 0;
        chk("pal_confirm", 32'(dut.r_state), 32'(ST_PAL_CONFIRM));
        tick();
        chk("pal_decline", 32'(bus.pal_start), 1);
        bus.pal_done = 1;
        tick();
        bus.pal_done = 0;
        bus.key_enter_pal = 1; bus.cur_x = 5; bus.cur_y = 10;
        tick();
        bus.key_enter_pal = 0;
        chk("set_color_pending", 32'(bus.color), 32'hFF);
        tick();
        chk("set_color", 32'(bus.color), 32'h5A);

        // 1x1 stamps with new colour, then erase
        bus.cur_x = 1; bus.cur_y = 1; bus.brush_size = 0; bus.key_enter = 1;
        tick();
        bus.key_enter = 0;
        tick();
        chk("s3_p0", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd1, 8'd1, 8'h5A});
        tick();
        chk("s3_end_wr_en", 32'(bus.wr_en), 0);
        bus.erase = 1; bus.key_enter = 1;
        tick();
        bus.key_enter = 0; bus.erase = 0;
        tick();
        chk("s4_erase", {bus.wr_en, 23'd0, bus.px_data}, {1'b1, 23'd0, 8'h00});
        tick();
        chk("s4_writes", 32'(wcount), 7);

        // back-pressure on the second pixel, then reset mid-stamp
        bus.cur_x = 2; bus.cur_y = 3; bus.brush_size = 1; bus.key_enter = 1;
        tick();
        bus.key_enter = 0;
        tick();
        chk("s5_p0", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd2, 8'd3, 8'h5A});
        tick();
        bus.wr_ready = 0; bus.cur_x = 40; bus.brush_size = 3;
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.px_data} !== {1'b1, 6'd3, 6'd3, 8'h5A}) viol++;
        end
        chk("s5_stall_hold", 32'(viol), 0);
        bus.wr_ready = 1;
        tick();
        chk("s5_p2", {bus.wr_en, 7'd0, 2'd0, bus.wr_x, 2'd0, bus.wr_y, bus.px_data}, {1'b1, 7'd0, 8'd2, 8'd4, 8'h5A});
        chk("s5_writes", 32'(wcount), 9);
        rst = 1;
        #1;
        chk("midrst_wr_en", 32'(bus.wr_en), 0);
        chk("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("midrst_color", 32'(bus.color), 32'hFF);
        rst = 0;

        // both keys high: palette wins, nothing written
        bus.key_pal = 1; bus.key_enter = 1;
        tick(); tick();
        bus.key_pal = 0; bus.key_enter = 0;
        tick();
        chk("prio_pal_start", 32'(bus.pal_start), 1);
        chk("prio_wr_en", 32'(bus.wr_en), 0);
        tick();
        chk("prio_writes", 32'(wcount), 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
